alu_logic: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shifter.sv | 30 +++
 rtl/alu_logic.sv | 93 +++++++++
 tb/tb_alu_logic.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the RV32I execute-stage ALU: operation
//                select codes, shifter modes and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0100,
        ALU_SLTU = 4'b0110,
        ALU_XOR  = 4'b1000,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011,
        ALU_OR   = 4'b1100,
        ALU_AND  = 4'b1110
    } alu_sel_e;

    localparam logic [1:0] C_SHIFT_SLL = 2'b00;
    localparam logic [1:0] C_SHIFT_SRL = 2'b01;
    localparam logic [1:0] C_SHIFT_SRA = 2'b10;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shifter
//  Description : Combinational barrel shifter for SLL / SRL / SRA on a
//                32-bit operand with a 5-bit shift amount.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  logic [1:0]      mode,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (mode)
            C_SHIFT_SLL: result = data << shamt;
            C_SHIFT_SRL: result = data >> shamt;
            C_SHIFT_SRA: result = $unsigned($signed(data) >>> shamt);
            default:     result = '0;
        endcase
    end

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu_logic.sv
`default_nettype none
// ============================================================================
//  Module      : alu_logic
//  Description : RV32I integer ALU with a registered result (1-cycle latency).
//                Optional macro ALU_FLAGS_EN adds registered zero/neg flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_logic
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [3:0]      ALUSel,
`ifdef ALU_FLAGS_EN
    output logic            zero,
    output logic            neg,
`endif
    output logic [XLEN-1:0] ALUop
);

    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_shift_result;
    logic [1:0]      w_shift_mode;
    logic [XLEN-1:0] r_aluop;

    always_comb begin
        w_shift_mode = C_SHIFT_SLL;
        if (ALUSel == ALU_SRL)
            w_shift_mode = C_SHIFT_SRL;
        else if (ALUSel == ALU_SRA)
            w_shift_mode = C_SHIFT_SRA;
    end

    alu_shifter #(
        .XLEN   (XLEN)
    ) u_shifter (
        .data   (data1),
        .shamt  (data2[4:0]),
        .mode   (w_shift_mode),
        .result (w_shift_result)
    );

    // Unassigned select codes fall through to zero.
    always_comb begin
        w_result = '0;
        case (ALUSel)
            ALU_ADD:  w_result = data1 + data2;
            ALU_SUB:  w_result = data1 - data2;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_result = w_shift_result;
            ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
            ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (data1 < data2)};
            ALU_XOR:  w_result = data1 ^ data2;
            ALU_OR:   w_result = data1 | data2;
            ALU_AND:  w_result = data1 & data2;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_aluop <= '0;
        else
            r_aluop <= w_result;
    end

    assign ALUop = r_aluop;

`ifdef ALU_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            r_zero <= (w_result == '0);
            r_neg  <= w_result[XLEN-1];
        end
    end

    assign zero = r_zero;
    assign neg  = r_neg;
`endif

endmodule : alu_logic
`default_nettype wire

// File: tb/tb_alu_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_logic
//  Description : Directed, table-driven self-checking bench for alu_logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_logic;

    logic        clk;
    logic        rst;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [3:0]  ALUSel;
    logic [31:0] ALUop;
`ifdef ALU_FLAGS_EN
    logic        zero;
    logic        neg;
`endif

    int total;
    int bad;

    alu_logic #(
        .XLEN   (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data1  (data1),
        .data2  (data2),
        .ALUSel (ALUSel),
`ifdef ALU_FLAGS_EN
        .zero   (zero),
        .neg    (neg),
`endif
        .ALUop  (ALUop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic [31:0] exp);
        vec_t v;
        v.rst = r; v.a = a; v.b = b; v.sel = sel; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Drive at the falling edge, check 1 time unit after the rising edge.
    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] exp, input string name);
        @(negedge clk);
        rst = r; data1 = a; data2 = b; ALUSel = sel;
        @(posedge clk);
        #1;
        check32(name, ALUop, exp);
`ifdef ALU_FLAGS_EN
        check32({name, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0) && !r ? 1'b1 : 1'b0});
        check32({name, "_neg"},  {31'd0, neg},  {31'd0, r ? 1'b0 : exp[31]});
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; data1 = '0; data2 = '0; ALUSel = 4'b0000;

        // Reset hold, then wraparound add on release
        add_vec(1'b1, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000);
        add_vec(1'b1, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000);
        add_vec(1'b0, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h00000000);
        // Operation sweep
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b0000, 32'hF0000005);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b0001, 32'hEFFFFFFB);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b0010, 32'h00000000);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b0100, 32'h00000001);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b0110, 32'h00000000);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1000, 32'hF0000005);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1010, 32'h07800000);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1011, 32'hFF800000);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1100, 32'hF0000005);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1110, 32'h00000000);
        add_vec(1'b0, 32'hF0000000, 32'd5, 4'b1111, 32'h00000000);
        // Undefined codes with operands that would give nonzero results
        add_vec(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'b0011, 32'h00000000);
        add_vec(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'b0101, 32'h00000000);
        add_vec(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'b0111, 32'h00000000);
        add_vec(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'b1001, 32'h00000000);
        add_vec(1'b0, 32'h12345678, 32'h0F0F0F0F, 4'b1101, 32'h00000000);
        // Shift amount masking
        add_vec(1'b0, 32'h00000001, 32'd33, 4'b0010, 32'h00000002);
        add_vec(1'b0, 32'h80000000, 32'd31, 4'b1011, 32'hFFFFFFFF);
        add_vec(1'b0, 32'h80000000, 32'd31, 4'b1010, 32'h00000001);
        add_vec(1'b0, 32'h80000000, 32'd36, 4'b1010, 32'h08000000);
        // Compare boundaries
        add_vec(1'b0, 32'h7FFFFFFF, 32'h80000000, 4'b0100, 32'h00000000);
        add_vec(1'b0, 32'h7FFFFFFF, 32'h80000000, 4'b0110, 32'h00000001);
        add_vec(1'b0, 32'h80000000, 32'h7FFFFFFF, 4'b0100, 32'h00000001);
        add_vec(1'b0, 32'h80000000, 32'h7FFFFFFF, 4'b0110, 32'h00000000);
        add_vec(1'b0, 32'd5, 32'd5, 4'b0100, 32'h00000000);
        add_vec(1'b0, 32'd5, 32'd5, 4'b0110, 32'h00000000);
        // Back-to-back select changes
        add_vec(1'b0, 32'd3, 32'd5, 4'b0000, 32'h00000008);
        add_vec(1'b0, 32'd3, 32'd5, 4'b0001, 32'hFFFFFFFE);
        add_vec(1'b0, 32'd3, 32'd5, 4'b1110, 32'h00000001);
        // Flag-relevant results
        add_vec(1'b0, 32'd7, 32'd7, 4'b0001, 32'h00000000);
        add_vec(1'b0, 32'd0, 32'd1, 4'b0001, 32'hFFFFFFFF);

        foreach (vecs[i])
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp,
                  $sformatf("vec%0d", i));

        // Reset asserted mid-stream wins over the computation, then recovers
        apply(1'b0, 32'd3, 32'd5, 4'b0000, 32'h00000008, "pre_rst");
        apply(1'b1, 32'd3, 32'd5, 4'b0000, 32'h00000000, "mid_rst");
        apply(1'b0, 32'd3, 32'd5, 4'b0001, 32'hFFFFFFFE, "post_rst");

        // Inputs changed between edges must not disturb the registered result
        apply(1'b0, 32'h0000AAAA, 32'h00005555, 4'b1100, 32'h0000FFFF, "or_hold");
        data1 = 32'h11111111; data2 = 32'h22222222; ALUSel = 4'b0000;
        @(negedge clk);
        check32("hold_mid_cycle", ALUop, 32'h0000FFFF);
        @(posedge clk);
        #1;
        check32("hold_next_edge", ALUop, 32'h33333333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_logic
`default_nettype wire
